// File: rtl/matrix_mult_sequencer_pkg.sv
// Shared definitions for the matrix multiply sequencer slice.
//   - default widths for dimensions, operands, accumulator and RAM address
//   - sequencer FSM state enumeration
package matrix_pkg;

  localparam int unsigned DIM_W_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ACC_W_DEF  = 128;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_OUTPUT,
    S_DONE
  } state_e;

endpackage

// File: rtl/matrix_mult_sequencer_if.sv
// Bundle of the sequencer's command, operand-RAM and result-stream signals.
//   master : command issuer / RAM owner / result consumer side
//   slave  : the sequencer itself
interface matrix_mult_sequencer_if
  import matrix_pkg::*;
#(
  parameter int unsigned DIM_W  = DIM_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  // command
  logic              start_valid;
  logic              start_ready;
  logic [DIM_W-1:0]  R1;
  logic [DIM_W-1:0]  C1;
  logic [DIM_W-1:0]  R2;
  logic [DIM_W-1:0]  C2;
  // operand RAMs
  logic              a_rd_en;
  logic              b_rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] a_rdata;
  logic [DATA_W-1:0] b_rdata;
  // result stream
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic [DIM_W-1:0]  res_row;
  logic [DIM_W-1:0]  res_col;

  modport master (
    output start_valid, R1, C1, R2, C2, a_rdata, b_rdata, res_ready,
    input  start_ready, a_rd_en, b_rd_en, a_addr, b_addr,
           res_valid, res_data, res_row, res_col
  );

  modport slave (
    input  start_valid, R1, C1, R2, C2, a_rdata, b_rdata, res_ready,
    output start_ready, a_rd_en, b_rd_en, a_addr, b_addr,
           res_valid, res_data, res_row, res_col
  );

endinterface

// File: rtl/matrix_mult_sequencer_mac.sv
// Registered unsigned multiply-accumulate.
//   CLK, RST_N : clock, async active-low reset
//   clr_load   : with en, load the product instead of adding it
//   en         : a/b carry a valid operand pair this cycle
//   a, b       : operands
//   acc        : running sum, wraps modulo 2^ACC_W
module matrix_mac
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              clr_load,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    acc_q;

  assign prod     = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= clr_load ? prod_ext : acc_q + prod_ext;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matrix_mult_sequencer.sv
// Matrix multiply sequencer: validates a command, walks i/j/k over two
// row-major operand RAMs and streams C[i][j] out in row-major order.
//   CLK, RST_N : clock, async active-low reset
//   bus        : command, operand-RAM and result-stream signals (slave side)
//   busy       : high whenever not idle
//   done       : one-cycle pulse after the last element is accepted
//   err        : one-cycle pulse after a rejected command
module matrix_mult_sequencer
  import matrix_pkg::*;
#(
  parameter int unsigned DIM_W  = DIM_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  matrix_mult_sequencer_if.slave  bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DIM_W-1:0] r1_q, r1_d, c1_q, c1_d, c2_q, c2_d;
  logic             rd_q, first_q, err_q, err_d;
  logic             rd_en, accept, cmd_bad;
  logic [ACC_W-1:0] acc;

  assign cmd_bad = (bus.C1 != bus.R2) || (bus.R1 == '0) || (bus.C1 == '0) ||
                   (bus.R2 == '0) || (bus.C2 == '0);

  // start_ready is held low while reset is asserted so every output is 0
  assign bus.start_ready = (state_q == S_IDLE) && RST_N;
  assign accept          = bus.start_valid && bus.start_ready;

  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    r1_d          = r1_q;
    c1_d          = c1_q;
    c2_d          = c2_q;
    err_d         = 1'b0;
    rd_en         = 1'b0;
    bus.res_valid = 1'b0;
    done          = 1'b0;
    busy          = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            r1_d    = bus.R1;
            c1_d    = bus.C1;
            c2_d    = bus.C2;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        rd_en = 1'b1;
        k_d   = k_q + DIM_W'(1);
        if (k_q == c1_q - DIM_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_OUTPUT;
      S_OUTPUT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          k_d     = '0;
          state_d = S_FETCH;
          if (j_q == c2_q - DIM_W'(1)) begin
            j_d = '0;
            if (i_q == r1_q - DIM_W'(1)) state_d = S_DONE;
            else                         i_d     = i_q + DIM_W'(1);
          end else begin
            j_d = j_q + DIM_W'(1);
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      r1_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      rd_q    <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      r1_q    <= r1_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      // RAM data lags the strobe by one cycle; track strobe and first-of-element with it
      rd_q    <= rd_en;
      first_q <= rd_en && (k_q == '0);
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.a_addr = '0;
    bus.b_addr = '0;
    if (rd_en) begin
      bus.a_addr = ADDR_W'(i_q) * ADDR_W'(c1_q) + ADDR_W'(k_q);
      bus.b_addr = ADDR_W'(k_q) * ADDR_W'(c2_q) + ADDR_W'(j_q);
    end
  end

  matrix_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clr_load(first_q),
    .en      (rd_q),
    .a       (bus.a_rdata),
    .b       (bus.b_rdata),
    .acc     (acc)
  );

  assign bus.a_rd_en  = rd_en;
  assign bus.b_rd_en  = rd_en;
  assign bus.res_data = acc;
  assign bus.res_row  = i_q;
  assign bus.res_col  = j_q;
  assign err          = err_q;

endmodule
